serial_mag_cmp: RTL
===================

SERIAL_MAG_CMP -- requirements
Module: serial_mag_cmp

Interface
REQ-001 Parameter: WIDTH, 16, operand width in bits; SHALL be >= 2.
REQ-002 Parameter: DIGIT, 1, bits compared per clock; SHALL divide WIDTH exactly, else elaboration SHALL fail.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: start  input  1  request a compare; sampled only in IDLE.
REQ-006 Port: A  input  WIDTH  operand A; captured on the edge that accepts start.
REQ-007 Port: B  input  WIDTH  operand B; captured on the edge that accepts start.
REQ-008 Port: signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; captured with A and B.
REQ-009 Port: busy  output  1  high whenever state is not IDLE.
REQ-010 Port: done  output  1  single-cycle pulse; results are valid in this cycle.
REQ-011 Port: AgtBo  output  1  registered result, A > B.
REQ-012 Port: AeqBo  output  1  registered result, A == B.
REQ-013 Port: AltBo  output  1  registered result, A < B.

Function
REQ-014 The block SHALL define N = WIDTH/DIGIT and a digit counter of max(1, clog2(N)) bits.
REQ-015 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-016 In IDLE with start=1 on an edge, the block SHALL:
- capture A, B and signed_mode;
- clear the counter to 0;
- set the running flags to gt=0, eq=1, lt=0;
- move to RUN.
REQ-017 In IDLE with start=0, the block SHALL stay in IDLE.
REQ-018 In signed_mode the block SHALL invert bit WIDTH-1 of both captured operands at capture (offset-binary conversion); the compare datapath SHALL otherwise be identical in both modes.
REQ-019 Each RUN edge SHALL compare digit[cnt], least-significant digit first, as an unsigned DIGIT-bit value:
- digit_A > digit_B: running = gt;
- digit_A < digit_B: running = lt;
- equal: running flags unchanged.
REQ-020 In RUN the counter SHALL increment by 1 each edge.
REQ-021 On the RUN edge that processes digit N-1, the block SHALL:
- load the final running flags into AgtBo/AeqBo/AltBo;
- move to DONE.
REQ-022 In DONE, done SHALL be 1 for exactly one cycle, and the next edge SHALL return the FSM to IDLE.
REQ-023 start asserted in RUN or DONE SHALL be ignored, and operands SHALL NOT change.
REQ-024 Latency: if start is accepted at edge k, done and valid results SHALL appear in the cycle after edge k+N.
REQ-025 Throughput: with start held high, the block SHALL accept a new compare every N+2 edges.
REQ-026 After the first completion, exactly one of AgtBo/AeqBo/AltBo SHALL be 1.
REQ-027 Result outputs SHALL hold their value until the next DONE entry; they SHALL NOT change during RUN.
REQ-028 For N=1 the block SHALL spend exactly one edge in RUN.

Reset
REQ-029 When rst_n=0, the block SHALL immediately and asynchronously force:
- state = IDLE;
- counter = 0;
- busy = 0;
- done = 0;
- AgtBo = AeqBo = AltBo = 0;
- running flags = eq.
REQ-030 Reset asserted in RUN or DONE SHALL abort the operation with no done pulse; the first start after rst_n returns high SHALL be accepted normally.

Verification
REQ-031 The bench SHALL cover the following directed scenarios with WIDTH=8, DIGIT=2 (N=4):
- A=0x5A, B=0x5A, unsigned, start at edge k -> done in the cycle after edge k+4, AeqBo=1, busy high from edge k to edge k+5.
- A=0x80, B=0x7F, unsigned -> AgtBo=1; same operands with signed_mode=1 -> AltBo=1.
- A=0x12, B=0x13 (only the LSB digit differs) -> AltBo=1; A=0xC1, B=0x41 -> AgtBo=1 (MSB digit overrides an equal lower digit).
- Start accepted with A=0x10, B=0x20, then start pulsed in RUN with A=0xFF, B=0x00 -> result AltBo=1, exactly one done pulse.
- rst_n low for 1 cycle during the second RUN edge -> all outputs 0 at once, no done pulse; then A=0x03, B=0x02 -> AgtBo=1 after normal latency.
- start held high for 3 operations -> done pulses spaced 6 cycles apart, with results matching each captured operand pair.

Source files
------------

// File: rtl/serial_mag_cmp_if.sv
// rtl/serial_mag_cmp_if.sv - request/result bundle for the serial magnitude comparator
interface serial_mag_cmp_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             signed_mode;
  logic             busy;
  logic             done;
  logic             AgtBo;
  logic             AeqBo;
  logic             AltBo;

  modport master (
    output start, A, B, signed_mode,
    input  busy, done, AgtBo, AeqBo, AltBo
  );

  modport slave (
    input  start, A, B, signed_mode,
    output busy, done, AgtBo, AeqBo, AltBo
  );
endinterface

// File: rtl/serial_mag_cmp.sv
// rtl/serial_mag_cmp.sv - digit-serial magnitude comparator, LSB digit first
module serial_mag_cmp #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_mag_cmp_if.slave  bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : gBadParams
      $error("serial_mag_cmp: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT            state, nextState;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opA, opB;
  logic             gt, eq, lt;
  logic             nextGt, nextEq, nextLt;
  logic [DIGIT-1:0] digA, digB;
  logic             lastDigit;
  logic             busyW, doneW;
  logic             resGt, resEq, resLt;

  // Flipping the sign bit maps two's complement onto offset binary,
  // so one unsigned datapath serves both modes.
  logic [WIDTH-1:0] signFlip;
  assign signFlip = {bus.signed_mode, {(WIDTH-1){1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    busyW     = 1'b0;
    doneW     = 1'b0;
    digA      = opA[cnt*DIGIT +: DIGIT];
    digB      = opB[cnt*DIGIT +: DIGIT];
    lastDigit = (cnt == CW'(N - 1));
    nextGt    = gt;
    nextEq    = eq;
    nextLt    = lt;
    // Higher digits are seen later, so any inequality simply overwrites.
    if (digA > digB) begin
      nextGt = 1'b1; nextEq = 1'b0; nextLt = 1'b0;
    end else if (digA < digB) begin
      nextGt = 1'b0; nextEq = 1'b0; nextLt = 1'b1;
    end
    case (state)
      IDLE: if (bus.start) nextState = RUN;
      RUN: begin
        busyW = 1'b1;
        if (lastDigit) nextState = DONE;
      end
      DONE: begin
        busyW     = 1'b1;
        doneW     = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      opA   <= '0;
      opB   <= '0;
      gt    <= 1'b0;
      eq    <= 1'b1;
      lt    <= 1'b0;
      resGt <= 1'b0;
      resEq <= 1'b0;
      resLt <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          opA <= bus.A ^ signFlip;
          opB <= bus.B ^ signFlip;
          cnt <= '0;
          gt  <= 1'b0;
          eq  <= 1'b1;
          lt  <= 1'b0;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          gt  <= nextGt;
          eq  <= nextEq;
          lt  <= nextLt;
          if (lastDigit) begin
            resGt <= nextGt;
            resEq <= nextEq;
            resLt <= nextLt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = busyW;
  assign bus.done  = doneW;
  assign bus.AgtBo = resGt;
  assign bus.AeqBo = resEq;
  assign bus.AltBo = resLt;
endmodule
